// File: rtl/uart_tx_sched_if.sv
// Link between the TX scheduler and the single UART transmitter instance.
// Handshake: TX_START is a one-cycle strobe that hands TX_DATA over; the transmitter
// answers by raising TX_BUSY within a few cycles and drops it once the frame is on the pin.
interface uart_tx_sched_if;
  logic       TX_START;
  logic [7:0] TX_DATA;
  logic       TX_BUSY;

  modport master (output TX_START, output TX_DATA, input TX_BUSY);
  modport slave  (input TX_START, input TX_DATA, output TX_BUSY);
endinterface

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between NUM_REQ byte sources; round-robin by default,
// fixed priority (lowest index wins) when UART_TX_SCHED_FIXED_PRIO_EN is defined.
module uart_tx_sched #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NUM_REQ-1:0]   REQ,
  input  logic [8*NUM_REQ-1:0] DATA,
  output logic [NUM_REQ-1:0]   ACK,
  uart_tx_sched_if.master      tx,
  output logic                 ACTIVE,
  output logic [2:0]           GNT_ID,
  output logic                 ERR,
  input  logic                 ERR_CLR,
  output logic [1:0]           STATE_DBG
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [7:0] TERM_CNT = 8'(START_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic [63:0] data_ext;
  logic        found;
  logic [2:0]  win;

  assign STATE_DBG = state;
  assign cnt_inc   = cnt + 8'd1;
  assign data_ext  = 64'(DATA);

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    win   = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && REQ[k]) begin
        found = 1'b1;
        win   = 3'(k);
      end
    end
  end
`else
  logic [2:0] ptr;
  logic [7:0] req_ext;
  logic [3:0] cand;

  // Search upward from the pointer, wrapping at NUM_REQ-1 back to 0.
  always_comb begin
    found   = 1'b0;
    win     = 3'd0;
    cand    = 4'd0;
    req_ext = 8'(REQ);
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!found && req_ext[cand[2:0]]) begin
        found = 1'b1;
        win   = cand[2:0];
      end
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      ACK         <= '0;
      tx.TX_START <= 1'b0;
      tx.TX_DATA  <= 8'h00;
      ACTIVE      <= 1'b0;
      GNT_ID      <= 3'd0;
      ERR         <= 1'b0;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
      ptr         <= 3'd0;
`endif
    end else begin
      ACK         <= '0;
      tx.TX_START <= 1'b0;
      if (ERR_CLR) ERR <= 1'b0;

      case (state)
        ST_IDLE: begin
          // A busy transmitter may still be finishing a frame started before a reset.
          if (found && !tx.TX_BUSY) begin
            tx.TX_DATA  <= data_ext[{win, 3'b000} +: 8];
            GNT_ID      <= win;
            ACK         <= NUM_REQ'(1) << win;
            tx.TX_START <= 1'b1;
            ACTIVE      <= 1'b1;
            state       <= ST_START;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
            ptr         <= (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;
`endif
          end
        end

        ST_START: begin
          cnt   <= 8'd0;
          state <= ST_WAIT_BUSY;
        end

        ST_WAIT_BUSY: begin
          if (tx.TX_BUSY) begin
            state <= ST_WAIT_DONE;
          end else begin
            cnt <= cnt_inc;
            // No BUSY response in time: drop the byte and flag it; the set beats ERR_CLR.
            if (cnt_inc == TERM_CNT) begin
              ERR    <= 1'b1;
              ACTIVE <= 1'b0;
              state  <= ST_IDLE;
            end
          end
        end

        ST_WAIT_DONE: begin
          if (!tx.TX_BUSY) begin
            ACTIVE <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        default: begin
          ACTIVE <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: reset, single frame, arbitration order,
// start timeout, busy-at-launch and reset mid-frame.
module tb_uart_tx_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic        active;
  logic [2:0]  gnt_id;
  logic        err;
  logic        err_clr;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  uart_tx_sched_if txif ();

  uart_tx_sched #(.NUM_REQ(4), .START_TIMEOUT(16)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .REQ       (req),
    .DATA      (data),
    .ACK       (ack),
    .tx        (txif),
    .ACTIVE    (active),
    .GNT_ID    (gnt_id),
    .ERR       (err),
    .ERR_CLR   (err_clr),
    .STATE_DBG (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n        = 1'b0;
    req          = 4'b0000;
    data         = 32'h0;
    err_clr      = 1'b0;
    txif.TX_BUSY = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  // Returns the number of negedges until TX_START is seen, or -1 on timeout.
  task automatic wait_start(input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (txif.TX_START !== 1'b1 && n < max_cyc);
    if (txif.TX_START !== 1'b1) n = -1;
  endtask

  // Transmitter model: BUSY rises one negedge after the start cycle and is held.
  task automatic serve(input int hold);
    @(negedge clk);
    txif.TX_BUSY = 1'b1;
    repeat (hold) @(negedge clk);
    txif.TX_BUSY = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; req = 4'b0; data = 32'h0; err_clr = 1'b0; txif.TX_BUSY = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    checks++; if (txif.TX_START !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", txif.TX_START); end
    checks++; if (txif.TX_DATA !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", txif.TX_DATA); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active); end
    checks++; if (gnt_id !== 3'd0) begin errors++; $display("FAIL reset_gnt_id: got %0d expected 0", gnt_id); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    bit stable;
    do_reset();
    data = 32'h33_A5_11_00;
    req  = 4'b0100;
    wait_start(6, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL single_latency: got %0d expected 1", n); end
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b expected 0100", ack); end
    checks++; if (txif.TX_DATA !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", txif.TX_DATA); end
    checks++; if (gnt_id !== 3'd2) begin errors++; $display("FAIL single_gnt: got %0d expected 2", gnt_id); end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL single_active: got %b expected 1", active); end
    @(negedge clk);
    req = 4'b0000;
    txif.TX_BUSY = 1'b1;
    checks++; if ({ack, txif.TX_START} !== 5'b0) begin errors++; $display("FAIL single_pulse_width: got ack=%b start=%b expected 0", ack, txif.TX_START); end
    stable = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (txif.TX_DATA !== 8'hA5 || active !== 1'b1 || txif.TX_START !== 1'b0) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL single_hold: got unstable data/active/start expected stable"); end
    txif.TX_BUSY = 1'b0;
    @(negedge clk);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL single_active_drop: got %b expected 0", active); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL single_idle: got %0d expected 0", state_dbg); end
    checks++; if (txif.TX_DATA !== 8'hA5) begin errors++; $display("FAIL single_data_after: got %h expected a5", txif.TX_DATA); end
  endtask

  task automatic test_round_robin();
    int n;
    int exp_g[5];
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0, 0};
`else
    exp_g = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    data = 32'h13_12_11_10;
    req  = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_start(8, n);
      checks++; if (n !== ((f == 0) ? 1 : 2)) begin errors++; $display("FAIL rr_gap_%0d: got %0d expected %0d", f, n, (f == 0) ? 1 : 2); end
      checks++; if (gnt_id !== 3'(exp_g[f])) begin errors++; $display("FAIL rr_gnt_%0d: got %0d expected %0d", f, gnt_id, exp_g[f]); end
      checks++; if (ack !== 4'(1 << exp_g[f])) begin errors++; $display("FAIL rr_ack_%0d: got %b expected %b", f, ack, 4'(1 << exp_g[f])); end
      checks++; if (txif.TX_DATA !== 8'(8'h10 + exp_g[f])) begin errors++; $display("FAIL rr_data_%0d: got %h expected %h", f, txif.TX_DATA, 8'(8'h10 + exp_g[f])); end
      if (f == 4) req = 4'b0000;
      serve(4);
    end
    repeat (2) @(negedge clk);
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rr_idle: got %0d expected 0", state_dbg); end
  endtask

  task automatic test_priority();
    int n;
    int exp_g[4];
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    exp_g = '{1, 1, 1, 1};
`else
    exp_g = '{1, 3, 1, 3};
`endif
    do_reset();
    data = 32'hD3_C2_B1_A0;
    req  = 4'b1010;
    for (int f = 0; f < 4; f++) begin
      wait_start(8, n);
      checks++; if (n < 0) begin errors++; $display("FAIL prio_start_%0d: got timeout expected start", f); end
      checks++; if (gnt_id !== 3'(exp_g[f])) begin errors++; $display("FAIL prio_gnt_%0d: got %0d expected %0d", f, gnt_id, exp_g[f]); end
      checks++; if (txif.TX_DATA !== ((exp_g[f] == 1) ? 8'hB1 : 8'hD3)) begin errors++; $display("FAIL prio_data_%0d: got %h", f, txif.TX_DATA); end
      if (f == 3) req = 4'b0000;
      serve(3);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    int k;
    do_reset();
    data = 32'h0000_00C7;
    req  = 4'b0001;
    wait_start(6, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL to_first_start: got %0d expected 1", n); end
    k = 0;
    do begin @(negedge clk); k++; end while (err !== 1'b1 && k < 40);
    checks++; if (k !== 16) begin errors++; $display("FAIL to_err_delay: got %0d expected 16", k); end
    checks++; if (state_dbg !== 2'd0 || active !== 1'b0) begin errors++; $display("FAIL to_idle: got state=%0d active=%b expected 0/0", state_dbg, active); end
    wait_start(6, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL to_relaunch: got %0d expected 1", n); end
    req = 4'b0000;
    k = 0;
    do begin @(negedge clk); k++; end while (state_dbg !== 2'd0 && k < 40);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b expected 1", err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_clr: got %b expected 0", err); end

    // BUSY arriving on the terminal-count cycle must win over the timeout.
    req = 4'b0001;
    wait_start(6, n);
    req = 4'b0000;
    repeat (15) @(negedge clk);
    txif.TX_BUSY = 1'b1;
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_busy_wins_err: got %b expected 0", err); end
    checks++; if (state_dbg !== 2'd3) begin errors++; $display("FAIL to_busy_wins_state: got %0d expected 3", state_dbg); end
    txif.TX_BUSY = 1'b0;
    repeat (2) @(negedge clk);

    // A timeout coinciding with ERR_CLR still sets ERR.
    err_clr = 1'b1;
    req     = 4'b0001;
    wait_start(6, n);
    req = 4'b0000;
    k = 0;
    do begin @(negedge clk); k++; end while (err !== 1'b1 && k < 40);
    checks++; if (k !== 16) begin errors++; $display("FAIL to_set_wins: got %0d expected 16", k); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_clr_after_set: got %b expected 0", err); end
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_busy_at_launch();
    int n;
    bit any_start;
    do_reset();
    txif.TX_BUSY = 1'b1;
    data = 32'h0000_005C;
    req  = 4'b0001;
    any_start = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (txif.TX_START !== 1'b0) any_start = 1'b1;
    end
    checks++; if (any_start !== 1'b0) begin errors++; $display("FAIL busy_no_start: got start expected none"); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL busy_idle: got %0d expected 0", state_dbg); end
    txif.TX_BUSY = 1'b0;
    wait_start(6, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL busy_launch: got %0d expected 1", n); end
    checks++; if (txif.TX_DATA !== 8'h5C) begin errors++; $display("FAIL busy_data: got %h expected 5c", txif.TX_DATA); end
    req = 4'b0000;
    serve(3);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    int k;
    bit any_start;
    do_reset();
    data = 32'h005A_0000;
    req  = 4'b0100;
    wait_start(6, n);
    @(negedge clk);
    txif.TX_BUSY = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (state_dbg !== 2'd3 && k < 10);
    checks++; if (state_dbg !== 2'd3) begin errors++; $display("FAIL mid_wait_done: got %0d expected 3", state_dbg); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (active !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL mid_async_state: got active=%b state=%0d expected 0/0", active, state_dbg); end
    checks++; if (gnt_id !== 3'd0 || txif.TX_DATA !== 8'h00) begin errors++; $display("FAIL mid_async_regs: got gnt=%0d data=%h expected 0/00", gnt_id, txif.TX_DATA); end
    checks++; if (ack !== 4'b0 || txif.TX_START !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_async_pulses: got ack=%b start=%b err=%b expected 0", ack, txif.TX_START, err); end
    @(negedge clk);
    rst_n = 1'b1;
    any_start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (txif.TX_START !== 1'b0) any_start = 1'b1;
    end
    checks++; if (any_start !== 1'b0) begin errors++; $display("FAIL mid_hold_off: got start expected none"); end
    txif.TX_BUSY = 1'b0;
    wait_start(6, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL mid_relaunch: got %0d expected 1", n); end
    checks++; if (gnt_id !== 3'd2 || txif.TX_DATA !== 8'h5A) begin errors++; $display("FAIL mid_relaunch_data: got gnt=%0d data=%h expected 2/5a", gnt_id, txif.TX_DATA); end
    req = 4'b0000;
    serve(2);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_timeout();
    test_busy_at_launch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmitter between several byte sources. Each requester presents a byte plus a level request. The scheduler picks one requester, latches its byte, and issues a one-cycle start pulse to the transmitter. It then tracks the transmitter's busy flag until the frame completes. It sits between the application sources (switch/button logic, status reporters, debug dump) and the single UART TX instance driving the board pin.

## Interface
Parameters:
- NUM_REQ, default 4: number of requesters; legal range 2..8.
- START_TIMEOUT, default 16: CLK cycles allowed between TX_START and TX_BUSY rising; legal range 4..255.

Ports:
- CLK, input, 1: system clock (125 MHz on board).
- RST_N, input, 1: reset, asynchronous, active-low.
- REQ, input, NUM_REQ: level request per requester.
- DATA, input, 8*NUM_REQ: byte of requester i on DATA[8i+7:8i]. Must be stable while REQ[i] is high.
- ACK, output, NUM_REQ: one-cycle pulse on the granted requester when its byte has been latched.
- TX_START, output, 1: one-cycle start pulse to the UART transmitter.
- TX_DATA, output, 8: latched byte for the transmitter. Held stable from TX_START until the return to IDLE.
- TX_BUSY, input, 1: transmitter busy flag.
- ACTIVE, output, 1: high in every state except IDLE.
- GNT_ID, output, 3: index of the last granted requester.
- ERR, output, 1: sticky start-timeout flag.
- ERR_CLR, input, 1: synchronous clear for ERR.

## Operation
States: IDLE, START, WAIT_BUSY, WAIT_DONE.

- **IDLE:** launches a frame when any REQ bit is high and TX_BUSY = 0. On the launching edge:
  - register TX_DATA <= DATA of the winner g;
  - GNT_ID <= g;
  - ACK[g] <= 1, TX_START <= 1;
  - pointer <= (g+1) mod NUM_REQ;
  - go to START.
- **IDLE, no launch:** with REQ = 0, or with TX_BUSY = 1 (transmitter owned by external reset or in use), stay in IDLE.
- **Winner selection:** the first set REQ bit searching upward from the pointer, wrapping from NUM_REQ-1 to 0. The pointer resets to 0.
- **START:** exactly one cycle with TX_START = 1 and ACK[g] = 1. Clear the timeout counter. Go to WAIT_BUSY.
- **WAIT_BUSY:**
  - TX_BUSY = 1 → WAIT_DONE.
  - Otherwise increment the counter. When it reaches START_TIMEOUT-1, set ERR and go to IDLE; the byte is dropped.
  - TX_BUSY = 1 on the same cycle as the terminal count → TX_BUSY wins and ERR is not set.
- **WAIT_DONE:** TX_BUSY = 0 → IDLE.
- **REQ sampling:** REQ is sampled only in IDLE. A requester with more bytes keeps REQ high and updates DATA in the cycle after its ACK. A requester with no more bytes drops REQ in the cycle after ACK.
- **ERR_CLR:** clears ERR. If ERR_CLR and a new timeout occur in the same cycle, the set wins.
- **Reset mid-frame:** RST_N low forces IDLE immediately. The frame already in the transmitter is not aborted by this block. After release, the scheduler waits in IDLE for TX_BUSY = 0.

Reset values:
- ACK = 0, TX_START = 0, TX_DATA = 8'h00.
- ACTIVE = 0, GNT_ID = 0, ERR = 0.
- pointer = 0, counter = 0.

## Timing
- All outputs are registered.
- **Launch latency:** REQ sampled high in IDLE at edge n → TX_START and ACK[g] high during cycle n+1, for exactly 1 cycle each.
- **Re-arbitration gap:** at least 1 IDLE cycle after TX_BUSY falls before the next TX_START.
- **Start pulse width:** TX_START is a single cycle. The transmitter's input synchroniser plus edge detector must register it; BUSY is expected within 3 cycles, well inside START_TIMEOUT.
- **Throughput:** one byte per frame time plus 3 CLK cycles.
- **Requester turns:** no requester gets two consecutive grants while another REQ is high (round-robin build).

## Configuration
- **`UART_TX_SCHED_FIXED_PRIO_EN` defined:** fixed priority, lowest index wins. The pointer register is removed and GNT_ID still reports the winner. Starvation of high indices is accepted.
- **Not defined (default):** round-robin as described in Operation.

## Test plan
- **Single requester:** REQ = 4'b0100, DATA[23:16] = 8'hA5, TX_BUSY model rises 2 cycles after TX_START and is held for 100 cycles. Required: TX_START one cycle after REQ, ACK = 4'b0100 for 1 cycle, TX_DATA = 8'hA5 stable throughout, ACTIVE low 1 cycle after BUSY falls.
- **Round-robin, all requesters:** REQ = 4'b1111 held, bytes 8'h10..8'h13. Required: grants in order 0,1,2,3,0, TX_DATA matching each requester's byte, GNT_ID matching each grant.
- **Fixed priority:** built with `UART_TX_SCHED_FIXED_PRIO_EN`, REQ = 4'b1010. Required: requester 1 granted repeatedly, requester 3 never granted.
- **Start timeout:** TX_BUSY tied 0, REQ = 4'b0001. Required: ERR set 16 cycles after TX_START, state back in IDLE, relaunch 1 cycle later. ERR_CLR pulse clears ERR.
- **Busy at launch:** TX_BUSY = 1 with REQ = 4'b0001. Required: no TX_START until 1 cycle after TX_BUSY = 0.
- **Reset mid-frame:** RST_N low during WAIT_DONE. Required: all outputs at reset values immediately, without a CLK edge. After release with TX_BUSY still 1, no TX_START until BUSY falls.
